// File: rtl/parity_serial_tx.sv
// Parity-framed serializer: accepts a word on valid/ready, sends start, data LSB-first,
// parity and stop on a single idle-high line, each bit held CLKS_PER_BIT clocks.
module parity_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              par_out
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud_cnt, baud_n;
  logic [BIT_W-1:0]    bit_cnt, bit_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                tx_n, busy_n, ready_n, par_n;
  logic                bit_end;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ (ODD_PARITY != 0);
  endfunction

  // Next-state and registered-output decode
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    tx_n    = tx;
    busy_n  = busy;
    ready_n = din_ready;
    par_n   = par_out;
    bit_end = (baud_cnt == BAUD_LAST);

    if (state != IDLE) begin
      baud_n = bit_end ? '0 : baud_cnt + BAUD_W'(1);
    end

    case (state)
      IDLE: begin
        if (din_valid && din_ready) begin
          state_n = START;
          shreg_n = din;
          par_n   = calc_parity(din);
          ready_n = 1'b0;
          busy_n  = 1'b1;
          tx_n    = 1'b0;
          baud_n  = '0;
          bit_n   = '0;
        end else begin
          ready_n = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_n = PARITY;
            tx_n    = par_out;
            bit_n   = '0;
          end else begin
            // Shift now so the next data bit is already at shreg[1] for tx
            bit_n   = bit_cnt + BIT_W'(1);
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          ready_n = 1'b1;
          tx_n    = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        ready_n = 1'b0;
        tx_n    = 1'b1;
        baud_n  = '0;
        bit_n   = '0;
      end
    endcase
  end

  // Control and line state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      din_ready <= 1'b0;
      par_out   <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      tx        <= tx_n;
      busy      <= busy_n;
      din_ready <= ready_n;
      par_out   <= par_n;
    end
  end

  // Shift register holds payload only, so it carries no reset
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

endmodule
